// File: rtl/xcel_axi_read_master_pkg.sv
// Shared constants and types for the xcel AXI read master: burst codes,
// response codes, burst-size limits and FSM state encoding.
package xcel_axi_read_master_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RRESP_OKAY  = 2'b00;

    localparam int unsigned BOUNDARY_4K     = 4096;
    localparam int unsigned MAX_INCR_BEATS  = 256;
    localparam int unsigned MAX_FIXED_BEATS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/xcel_axi_read_master_if.sv
// AXI4 read-address and read-data channels between the read master and the slave.
// Handshake rule: a transfer happens on a rising clk edge where valid && ready; the
// source holds valid and its payload stable until then, and ready may depend on valid.
interface xcel_axi_read_master_if #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
);
    logic                  m_arvalid;
    logic                  m_arready;
    logic [AXI_AWIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [AXI_DWIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );
endinterface

// File: rtl/xcel_burst_splitter.sv
// Sizes the next burst of a request: at most 256 beats and never across a 4 KB page
// for INCR, at most 16 beats for FIXED; also returns the address after that burst.
module xcel_burst_splitter
    import xcel_axi_read_master_pkg::*;
#(
    parameter int AXI_AWIDTH = 32
) (
    input  logic [AXI_AWIDTH-1:0] addr,
    input  logic [32:0]           remaining,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [8:0]            beats,
    output logic [AXI_AWIDTH-1:0] next_addr
);
    logic [12:0] offset_beats;
    logic [12:0] page_beats;
    logic [8:0]  limit;

    always_comb begin
        // Counting in beats from the aligned start keeps the page limit at least 1.
        offset_beats = {1'b0, addr[11:0]} >> size;
        page_beats   = (13'(BOUNDARY_4K) >> size) - offset_beats;
        if (burst == BURST_FIXED) begin
            limit = 9'(MAX_FIXED_BEATS);
        end else if (page_beats < 13'(MAX_INCR_BEATS)) begin
            limit = page_beats[8:0];
        end else begin
            limit = 9'(MAX_INCR_BEATS);
        end
        if (remaining < {24'd0, limit}) begin
            beats = remaining[8:0];
        end else begin
            beats = limit;
        end
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else begin
            next_addr = addr + (AXI_AWIDTH'(beats) << size);
        end
    end
endmodule

// File: rtl/xcel_axi_read_master.sv
// Turns one xcel read request into a chain of AXI4 read bursts (one outstanding)
// and streams the returned beats straight through to the accelerator.
module xcel_axi_read_master
    import xcel_axi_read_master_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_AWIDTH-1:0] req_addr,
    input  logic [31:0]           req_len,
    input  logic [2:0]            req_size,
    input  logic [1:0]            req_burst,
    output logic [AXI_DWIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  busy,
    output logic                  rd_error,
    output state_t                dbg_state,
    xcel_axi_read_master_if.master axi
);
    localparam logic [2:0] NATIVE_SIZE = 3'($clog2(AXI_DWIDTH / 8));

    state_t                state;
    logic [AXI_AWIDTH-1:0] cur_addr;
    logic [32:0]           remaining;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [8:0]            beats_left;
    logic                  ar_valid;
    logic [AXI_AWIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;

    logic                  in_idle;
    logic                  req_ok;
    logic                  r_fire;
    logic                  last_beat;
    logic [AXI_AWIDTH-1:0] sp_addr;
    logic [AXI_AWIDTH-1:0] sp_next_addr;
    logic [32:0]           sp_remaining;
    logic [2:0]            sp_size;
    logic [1:0]            sp_burst;
    logic [8:0]            sp_beats;

    // cur_addr/remaining are advanced at the AR handshake, so during DATA the
    // splitter already describes the following burst and can issue it without a bubble.
    assign in_idle      = (state == ST_IDLE);
    assign sp_addr      = in_idle ? req_addr : cur_addr;
    assign sp_remaining = in_idle ? ({1'b0, req_len} + 33'd1) : remaining;
    assign sp_size      = in_idle ? req_size : size_q;
    assign sp_burst     = in_idle ? req_burst : burst_q;

    xcel_burst_splitter #(.AXI_AWIDTH(AXI_AWIDTH)) u_splitter (
        .addr      (sp_addr),
        .remaining (sp_remaining),
        .size      (sp_size),
        .burst     (sp_burst),
        .beats     (sp_beats),
        .next_addr (sp_next_addr)
    );

    assign req_ok = (req_size <= NATIVE_SIZE) &&
                    ((req_burst == BURST_INCR) || (req_burst == BURST_FIXED));

    assign req_ready      = in_idle;
    assign busy           = !in_idle;
    assign dbg_state      = state;
    assign data_out       = (state == ST_DATA) ? axi.m_rdata : '0;
    assign data_out_valid = (state == ST_DATA) && axi.m_rvalid;
    assign axi.m_rready   = (state == ST_DATA) && data_out_ready;
    assign r_fire         = data_out_valid && axi.m_rready;
    assign last_beat      = (beats_left == 9'd1);

    assign axi.m_arvalid  = ar_valid;
    assign axi.m_araddr   = ar_addr;
    assign axi.m_arlen    = ar_len;
    assign axi.m_arsize   = size_q;
    assign axi.m_arburst  = burst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beats_left <= '0;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            ar_len     <= '0;
            rd_error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            cur_addr  <= req_addr;
                            remaining <= sp_remaining;
                            size_q    <= req_size;
                            burst_q   <= req_burst;
                            rd_error  <= 1'b0;
                            ar_valid  <= 1'b1;
                            ar_addr   <= req_addr;
                            ar_len    <= 8'(sp_beats - 9'd1);
                            state     <= ST_ADDR;
                        end else begin
                            rd_error  <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (axi.m_arready) begin
                        ar_valid   <= 1'b0;
                        cur_addr   <= sp_next_addr;
                        remaining  <= remaining - 33'(sp_beats);
                        beats_left <= sp_beats;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        beats_left <= beats_left - 9'd1;
                        if ((axi.m_rresp != RRESP_OKAY) || (axi.m_rlast != last_beat)) begin
                            rd_error <= 1'b1;
                        end
                        if (last_beat) begin
                            if (remaining == 33'd0) begin
                                state <= ST_IDLE;
                            end else begin
                                ar_valid <= 1'b1;
                                ar_addr  <= cur_addr;
                                ar_len   <= 8'(sp_beats - 9'd1);
                                state    <= ST_ADDR;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
